// File: rtl/if_stage_prefetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its prefetch FIFO.
package if_stage_prefetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES       = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_prefetch_fifo.sv
// Prefetch FIFO holding {pc_plus4, instr} pairs; flush wins over push and pop.
module fetch_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [63:0]            push_data,
    output logic [63:0]            head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int PW = $clog2(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty     = (count == '0);
    assign full      = (count == (PW + 1)'(DEPTH));
    assign do_push   = push && !full && !flush;
    assign do_pop    = pop && !empty && !flush;
    assign head_data = mem[rd_ptr];

    // Pointers are exactly log2(DEPTH) bits so they wrap without explicit compare.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/if_stage_prefetch.sv
// Instruction fetch stage: one outstanding req/ack fetch at a time, results buffered in a prefetch FIFO.
module if_stage_prefetch
    import if_stage_prefetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Freeze,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Address,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    input  logic        Imem_Ack,
    input  logic [31:0] Imem_Data,
    output logic        Valid,
    output logic [31:0] Instruction,
    output logic [31:0] PC
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state;
    logic [31:0]   fetch_pc;
    logic [63:0]   head;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          flush;

    assign flush = Branch_Taken;
    assign push  = (state == WAIT) && Imem_Ack && !Branch_Taken && !fifo_full;
    assign pop   = Valid && !Freeze && !Branch_Taken;

    assign Valid       = !fifo_empty;
    assign Instruction = fifo_empty ? NOP_WORD : head[31:0];
    assign PC          = fifo_empty ? 32'h0 : head[63:32];

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_data ({Imem_Addr + WORD_BYTES, Imem_Data}),
        .head_data (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // A branch during an outstanding fetch cannot cancel it on the bus, so the
    // request is held in DROP until its ack arrives and the word is thrown away.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            Imem_Req  <= 1'b0;
            Imem_Addr <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (Branch_Taken) begin
                        fetch_pc <= word_align(Branch_Address);
                    end else if (fifo_count < CW'(DEPTH)) begin
                        Imem_Req  <= 1'b1;
                        Imem_Addr <= fetch_pc;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (Branch_Taken) begin
                        fetch_pc <= word_align(Branch_Address);
                        if (Imem_Ack) begin
                            Imem_Req <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            state <= DROP;
                        end
                    end else if (Imem_Ack) begin
                        fetch_pc <= fetch_pc + WORD_BYTES;
                        Imem_Req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                DROP: begin
                    if (Branch_Taken) begin
                        fetch_pc <= word_align(Branch_Address);
                    end
                    if (Imem_Ack) begin
                        Imem_Req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    Imem_Req <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage_prefetch.sv
// Randomised scoreboard bench for if_stage_prefetch: a memory model feeds expected words
// into a queue, and an independent monitor pops it whenever the stage hands an instruction on.
module tb_if_stage_prefetch;
    import if_stage_prefetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        Freeze;
    logic        Branch_Taken;
    logic [31:0] Branch_Address;
    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic        Imem_Ack;
    logic [31:0] Imem_Data;
    logic        Valid;
    logic [31:0] Instruction;
    logic [31:0] PC;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          pop_count = 0;
    int          lat_mode = 0;
    bit          stray_en = 1'b0;
    logic [31:0] exp_fetch = 32'h0;
    logic [31:0] fetch_snapshot = 32'h0;

    always #5 clk = ~clk;

    if_stage_prefetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .Freeze         (Freeze),
        .Branch_Taken   (Branch_Taken),
        .Branch_Address (Branch_Address),
        .Imem_Req       (Imem_Req),
        .Imem_Addr      (Imem_Addr),
        .Imem_Ack       (Imem_Ack),
        .Imem_Data      (Imem_Data),
        .Valid          (Valid),
        .Instruction    (Instruction),
        .PC             (PC)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // One call per cycle; a branch restarts the expected instruction stream at the aligned target.
    task automatic applyStimulus(input logic frz, input logic br, input logic [31:0] addr);
        @(negedge clk);
        #1;
        Freeze         = frz;
        Branch_Taken   = br;
        Branch_Address = addr;
        if (br) begin
            sb.delete();
            exp_fetch = {addr[31:2], 2'b00};
        end
    endtask

    task automatic waitReqAddr(input logic [31:0] a, input bit any_addr, input int budget, input string name);
        int n = 0;
        while (!(Imem_Req && (any_addr || Imem_Addr == a)) && n < budget) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            n++;
        end
        checks++;
        if (!(Imem_Req && (any_addr || Imem_Addr == a))) begin
            errors++;
            $display("[TB] FAIL %s timeout actual_req=%0b actual_addr=%h expected_addr=%h",
                     name, Imem_Req, Imem_Addr, a);
        end
    endtask

    task automatic assertResetNow(input int cycles);
        rst          = 1'b0;
        Freeze       = 1'b0;
        Branch_Taken = 1'b0;
        sb.delete();
        exp_fetch = 32'h0;
        #1;
        checkOutput("reset_req_drop", {31'h0, Imem_Req}, 32'h0);
        checkOutput("reset_valid_drop", {31'h0, Valid}, 32'h0);
        repeat (cycles) @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Memory model: serves one request at a time; any branch seen while it is outstanding kills its data.
    initial begin : memory_model
        bit          busy = 1'b0;
        bit          dead = 1'b0;
        int          left = 0;
        logic [31:0] req_addr = 32'h0;
        Imem_Ack  = 1'b0;
        Imem_Data = 32'h0;
        forever begin
            @(negedge clk);
            #2;
            Imem_Ack  = 1'b0;
            Imem_Data = $urandom;
            if (!rst) begin
                busy = 1'b0;
            end else begin
                if (busy) begin
                    checkOutput("req_held", {31'h0, Imem_Req}, 32'h1);
                    checkOutput("addr_stable", Imem_Addr, req_addr);
                end else if (Imem_Req) begin
                    busy     = 1'b1;
                    dead     = 1'b0;
                    req_addr = Imem_Addr;
                    left     = (lat_mode < 0) ? int'($urandom_range(4, 0)) : lat_mode;
                    checkOutput("req_addr", Imem_Addr, fetch_snapshot);
                end
                if (busy) begin
                    if (Branch_Taken) dead = 1'b1;
                    if (left == 0) begin
                        Imem_Ack  = 1'b1;
                        Imem_Data = mem_word(req_addr);
                        busy      = 1'b0;
                        if (!dead) begin
                            sb.push_back('{mem_word(req_addr), req_addr + 32'd4});
                            exp_fetch = req_addr + 32'd4;
                        end
                    end else begin
                        left--;
                    end
                end else if (stray_en && $urandom_range(19, 0) == 0) begin
                    Imem_Ack = 1'b1;
                end
            end
        end
    end

    initial begin : monitor
        bit          prev_branch = 1'b0;
        bit          prev_hold = 1'b0;
        logic [31:0] prev_instr = 32'h0;
        logic [31:0] prev_pc = 32'h0;
        exp_t        e;
        forever begin
            @(negedge clk);
            #3;
            fetch_snapshot = exp_fetch;
            if (!rst) begin
                prev_branch = 1'b0;
                prev_hold   = 1'b0;
            end else begin
                if (prev_branch) checkOutput("valid_after_branch", {31'h0, Valid}, 32'h0);
                if (prev_hold) begin
                    checkOutput("freeze_valid", {31'h0, Valid}, 32'h1);
                    checkOutput("freeze_instr", Instruction, prev_instr);
                    checkOutput("freeze_pc", PC, prev_pc);
                end
                if (!Valid) begin
                    checkOutput("idle_instr", Instruction, NOP_WORD);
                    checkOutput("idle_pc", PC, 32'h0);
                end else if (!Freeze && !Branch_Taken) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_instr actual=%h expected=none", Instruction);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("instr", Instruction, e.instr);
                        checkOutput("pc", PC, e.pc);
                        pop_count++;
                    end
                end
                prev_branch = Branch_Taken;
                prev_hold   = Valid && Freeze && !Branch_Taken;
                prev_instr  = Instruction;
                prev_pc     = PC;
            end
        end
    end

    initial begin : stimulus
        rst            = 1'b0;
        Freeze         = 1'b0;
        Branch_Taken   = 1'b0;
        Branch_Address = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_imem_req", {31'h0, Imem_Req}, 32'h0);
        checkOutput("reset_imem_addr", Imem_Addr, 32'h0);
        checkOutput("reset_valid", {31'h0, Valid}, 32'h0);
        checkOutput("reset_instr", Instruction, 32'h0);
        checkOutput("reset_pc", PC, 32'h0);
        rst = 1'b1;

        $display("[TB] zero-wait fetch");
        lat_mode  = 0;
        pop_count = 0;
        repeat (40) applyStimulus(1'b0, 1'b0, 32'h0);
        checks++;
        if (pop_count < 18 || pop_count > 20) begin
            errors++;
            $display("[TB] FAIL zero_wait_rate actual=%0d expected=18..20", pop_count);
        end

        $display("[TB] reset mid-request");
        lat_mode = 3;
        waitReqAddr(32'h0, 1'b1, 50, "wait_req_before_reset");
        assertResetNow(2);

        $display("[TB] freeze fill");
        applyStimulus(1'b1, 1'b1, 32'h200);
        repeat (35) applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("full_no_req", {31'h0, Imem_Req}, 32'h0);
        checkOutput("full_valid", {31'h0, Valid}, 32'h1);
        checkOutput("full_instr", Instruction, mem_word(32'h200));
        checkOutput("full_pc", PC, 32'h204);
        checkOutput("full_count", 32'(sb.size()), 32'(DEPTH));
        repeat (20) applyStimulus(1'b0, 1'b0, 32'h0);

        $display("[TB] branch while waiting");
        applyStimulus(1'b0, 1'b1, 32'h10);
        waitReqAddr(32'h10, 1'b0, 40, "wait_req_0x10");
        applyStimulus(1'b0, 1'b1, 32'h100);
        waitReqAddr(32'h100, 1'b0, 40, "wait_req_0x100");
        repeat (12) applyStimulus(1'b0, 1'b0, 32'h0);

        $display("[TB] branch with ack and freeze");
        lat_mode = 0;
        repeat (4) applyStimulus(1'b1, 1'b0, 32'h0);
        begin
            int n = 0;
            while (!Imem_Req && n < 20) begin
                applyStimulus(1'b1, 1'b0, 32'h0);
                n++;
            end
        end
        checkOutput("bafz_req_seen", {31'h0, Imem_Req}, 32'h1);
        checkOutput("bafz_valid_before", {31'h0, Valid}, 32'h1);
        applyStimulus(1'b1, 1'b1, 32'h300);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("bafz_valid_after", {31'h0, Valid}, 32'h0);
        waitReqAddr(32'h300, 1'b0, 20, "wait_req_0x300");
        repeat (10) applyStimulus(1'b0, 1'b0, 32'h0);

        $display("[TB] address wrap");
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFB);
        waitReqAddr(32'hFFFF_FFF8, 1'b0, 20, "wrap_req_fff8");
        waitReqAddr(32'hFFFF_FFFC, 1'b0, 20, "wrap_req_fffc");
        waitReqAddr(32'h0000_0000, 1'b0, 20, "wrap_req_0");
        repeat (8) applyStimulus(1'b0, 1'b0, 32'h0);

        $display("[TB] random traffic");
        lat_mode = -1;
        stray_en = 1'b1;
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(9, 0) < 3, $urandom_range(99, 0) < 4, $urandom);
        end
        stray_en = 1'b0;
        lat_mode = 0;
        repeat (10) applyStimulus(1'b0, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
